// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low glyph table,
// the all-off pattern, and the code-to-glyph lookup.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Codes A-F render dark unless hex_mode is set.
  function automatic logic [6:0] glyph_lookup(input logic [3:0] code, input logic hex_mode);
    logic [6:0] g;
    case (code)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    if (!hex_mode && code > 4'd9) g = SEG_OFF;
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational digit decoder: 4-bit code plus hex_mode to active-low segments,
// with a flag telling whether the code is displayable at all.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_n_o,
  output logic       shown_o
);

  assign seg_n_o = glyph_lookup(code_i, hex_mode_i);
  assign shown_o = hex_mode_i || (code_i <= 4'd9);

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit 7-segment driver: one digit per refresh slot, with a
// dead-time gap at the start of every slot to keep anode switching ghost-free.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  input  logic                    lz_en,
  input  logic                    hex_mode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic [2:0]              digit_idx
);

  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DEAD_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(BLANK_CYC);
  localparam logic [2:0]          IDX_LAST  = 3'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic                DP_IDLE   = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_IDLE   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [2:0]            idx_q, idx_d;
  logic [DEAD_W-1:0]     dead_q, dead_d;
  logic [4*N_DIGITS-1:0] dig_q, dig_d;
  logic [N_DIGITS-1:0]   dpin_q, dpin_d;
  logic [N_DIGITS-1:0]   blank_q, blank_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  tick;
  logic [3:0]            cur_code;
  logic                  cur_dp, cur_blank, cur_lz;
  logic [N_DIGITS-1:0]   lz_mask, onehot, an_on;
  logic                  all_zero;
  logic [6:0]            glyph_n;
  logic                  shown, lit, dp_on;

  assign tick = (pre_q == PRE_LAST);

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    pre_d  = tick ? '0 : pre_q + PRE_W'(1);
    idx_d  = idx_q;
    dead_d = dead_q;
    if (tick) begin
      idx_d  = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      dead_d = DEAD_LOAD;
    end else if (dead_q != '0) begin
      dead_d = dead_q - DEAD_W'(1);
    end

    dig_d   = load ? digits_in : dig_q;
    dpin_d  = load ? dp_in     : dpin_q;
    blank_d = load ? blank_in  : blank_q;
  end

  // Leading-zero mask walks from the most significant digit down; digit 0 is exempt.
  always_comb begin
    all_zero  = 1'b1;
    lz_mask   = '0;
    onehot    = '0;
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (dig_q[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_en && (i > 0) && all_zero;
      onehot[i]  = (idx_q == 3'(i));
      if (idx_q == 3'(i)) begin
        cur_code  = dig_q[4*i +: 4];
        cur_dp    = dpin_q[i];
        cur_blank = blank_q[i];
      end
    end
    cur_lz = |(lz_mask & onehot);
  end

  seg7_glyph u_glyph (
    .code_i     (cur_code),
    .hex_mode_i (hex_mode),
    .seg_n_o    (glyph_n),
    .shown_o    (shown)
  );

  always_comb begin
    lit   = (dead_q == '0) && !cur_blank && !cur_lz && shown;
    dp_on = lit && cur_dp;
    an_on = lit ? onehot : '0;
    seg_d = !lit ? SEG_IDLE : ((SEG_ACTIVE_LOW != 0) ? glyph_n : ~glyph_n);
    dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_on : dp_on;
    an_d  = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= 3'd0;
      dead_q  <= DEAD_LOAD;
      dig_q   <= '0;
      dpin_q  <= '0;
      blank_q <= '0;
      seg_q   <= SEG_IDLE;
      dp_q    <= DP_IDLE;
      an_q    <= AN_IDLE;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      dead_q  <= dead_d;
      dig_q   <= dig_d;
      dpin_q  <= dpin_d;
      blank_q <= blank_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: directed frames push per-slot expectations,
// a negedge monitor rebuilds each slot from the pins and compares.
module tb_seg7_scan_mux;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;

  logic        clk = 1'b0;
  logic        rst, load, lz_en, hex_mode;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [2:0]  digit_idx;

  seg7_scan_mux #(
    .N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYC(BLK),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en), .hex_mode(hex_mode),
    .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic       lit;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_slot(input logic [2:0] idx, input logic lit, input logic [6:0] s, input logic dpl);
    exp_t e;
    e.idx = idx;
    e.lit = lit;
    e.seg = lit ? s : 7'h7F;
    e.dp  = ~(lit & dpl);
    exp_q.push_back(e);
  endtask

  task automatic load_vals(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl,
                           input logic lz, input logic hx);
    @(negedge clk);
    digits_in = d;
    dp_in     = dpv;
    blank_in  = bl;
    lz_en     = lz;
    hex_mode  = hx;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_frame();
    mon_en = 1'b1;
    for (int c = 0; c < 120 && exp_q.size() != 0; c++) @(negedge clk);
    check("frame_done", exp_q.size(), 0);
    exp_q.delete();
    mon_en = 1'b0;
    @(negedge clk);
  endtask

  // Outputs seen at a negedge belong to the slot that digit_idx showed one cycle earlier.
  initial begin : monitor
    logic [2:0] prev_idx, cur_slot;
    logic       armed, incons, off_bad;
    int         off_cnt, lit_cnt;
    logic [3:0] l_an, exp_an;
    logic [6:0] l_seg;
    logic       l_dp;
    exp_t       e;
    prev_idx = 3'd0; cur_slot = 3'd0; armed = 1'b0;
    off_cnt = 0; lit_cnt = 0; incons = 1'b0; off_bad = 1'b0;
    l_an = 4'hF; l_seg = 7'h7F; l_dp = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_idx = 3'd0;
        cur_slot = 3'd0;
        armed    = 1'b0;
      end else begin
        if (prev_idx != cur_slot) begin
          if (armed && exp_q.size() == 0) armed = 1'b0;
          if (armed) begin
            e      = exp_q.pop_front();
            exp_an = e.lit ? ~(4'b0001 << e.idx) : 4'hF;
            check("slot_idx",   cur_slot, e.idx);
            check("off_cycles", off_cnt,  e.lit ? BLK : DIV);
            check("lit_cycles", lit_cnt,  e.lit ? DIV - BLK : 0);
            check("an",         l_an,     exp_an);
            check("seg",        l_seg,    e.seg);
            check("dp",         l_dp,     e.dp);
            check("off_clean",  off_bad,  1'b0);
            check("lit_stable", incons,   1'b0);
            if (exp_q.size() == 0) armed = 1'b0;
          end
          if (!armed && mon_en && prev_idx == 3'd0 && exp_q.size() > 0) armed = 1'b1;
          cur_slot = prev_idx;
          off_cnt = 0; lit_cnt = 0; incons = 1'b0; off_bad = 1'b0;
          l_an = 4'hF; l_seg = 7'h7F; l_dp = 1'b1;
        end
        if (an == 4'hF) begin
          off_cnt++;
          if (seg !== 7'h7F || dp !== 1'b1) off_bad = 1'b1;
        end else begin
          if (lit_cnt == 0) begin
            l_an = an; l_seg = seg; l_dp = dp;
          end else if (an !== l_an || seg !== l_seg || dp !== l_dp) begin
            incons = 1'b1;
          end
          lit_cnt++;
        end
        prev_idx = digit_idx;
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; load = 1'b0; lz_en = 1'b0; hex_mode = 1'b0;
    digits_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;

    repeat (3) @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp",  dp, 1'b1);
    check("rst_an",  an, 4'hF);
    check("rst_idx", digit_idx, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rel_2edges_an", an, 4'hF);
    @(negedge clk);
    check("rel_3edges_an",  an, 4'hE);
    check("rel_3edges_seg", seg, 7'h40);

    // Shadow is zero after reset: every digit shows 0.
    for (int i = 0; i < 4; i++) push_slot(3'(i), 1'b1, 7'h40, 1'b0);
    run_frame();

    load_vals(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0);
    push_slot(0, 1, 7'h19, 0); push_slot(1, 1, 7'h30, 0);
    push_slot(2, 1, 7'h24, 0); push_slot(3, 1, 7'h79, 0);
    run_frame();

    load_vals(16'h5678, 4'h0, 4'h0, 1'b0, 1'b0);
    push_slot(0, 1, 7'h00, 0); push_slot(1, 1, 7'h78, 0);
    push_slot(2, 1, 7'h02, 0); push_slot(3, 1, 7'h12, 0);
    run_frame();

    load_vals(16'h0070, 4'h0, 4'h0, 1'b1, 1'b0);
    push_slot(0, 1, 7'h40, 0); push_slot(1, 1, 7'h78, 0);
    push_slot(2, 0, 7'h7F, 0); push_slot(3, 0, 7'h7F, 0);
    run_frame();

    load_vals(16'h0000, 4'h0, 4'h0, 1'b1, 1'b0);
    push_slot(0, 1, 7'h40, 0); push_slot(1, 0, 7'h7F, 0);
    push_slot(2, 0, 7'h7F, 0); push_slot(3, 0, 7'h7F, 0);
    run_frame();

    // A zero below a nonzero digit is not leading.
    load_vals(16'h0905, 4'h0, 4'h0, 1'b1, 1'b0);
    push_slot(0, 1, 7'h12, 0); push_slot(1, 1, 7'h40, 0);
    push_slot(2, 1, 7'h10, 0); push_slot(3, 0, 7'h7F, 0);
    run_frame();

    load_vals(16'h000A, 4'h0, 4'h0, 1'b0, 1'b1);
    push_slot(0, 1, 7'h08, 0); push_slot(1, 1, 7'h40, 0);
    push_slot(2, 1, 7'h40, 0); push_slot(3, 1, 7'h40, 0);
    run_frame();

    load_vals(16'h000A, 4'h0, 4'h0, 1'b0, 1'b0);
    push_slot(0, 0, 7'h7F, 0); push_slot(1, 1, 7'h40, 0);
    push_slot(2, 1, 7'h40, 0); push_slot(3, 1, 7'h40, 0);
    run_frame();

    load_vals(16'hCDEF, 4'h0, 4'h0, 1'b0, 1'b1);
    push_slot(0, 1, 7'h0E, 0); push_slot(1, 1, 7'h06, 0);
    push_slot(2, 1, 7'h21, 0); push_slot(3, 1, 7'h46, 0);
    run_frame();

    load_vals(16'hAB00, 4'h0, 4'h0, 1'b1, 1'b1);
    push_slot(0, 1, 7'h40, 0); push_slot(1, 1, 7'h40, 0);
    push_slot(2, 1, 7'h03, 0); push_slot(3, 1, 7'h08, 0);
    run_frame();

    load_vals(16'h8888, 4'b0100, 4'b0001, 1'b0, 1'b0);
    push_slot(0, 0, 7'h7F, 0); push_slot(1, 1, 7'h00, 0);
    push_slot(2, 1, 7'h00, 1); push_slot(3, 1, 7'h00, 0);
    run_frame();

    // Mid-frame reset clears the shadow as well as the scan state.
    load_vals(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0);
    for (int c = 0; c < 100 && digit_idx != 3'd2; c++) @(negedge clk);
    check("reach_idx2", digit_idx, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_an",  an, 4'hF);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_idx", digit_idx, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_2edges_an", an, 4'hF);
    @(negedge clk);
    check("midrst_lit_an",  an, 4'hE);
    check("midrst_lit_seg", seg, 7'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
